// File: rtl/mips_memsys_pkg.sv
// Shared types for the 8-bit multicycle mips core and its boot/memory subsystem.
package mips_memsys_pkg;

  // Memory subsystem sequencing: reset hold, host image load, core release, run.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    RUN
  } memstate;

  // Control states of the multicycle core.
  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4,
    DECODE, MEMADR, LBRD, LBWR, SBWR,
    RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIWR
  } statetype;

  // Primary opcodes understood by the core.
  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    BEQ   = 6'b000100,
    ADDI  = 6'b001000,
    LB    = 6'b100000,
    SB    = 6'b101000
  } opcode;

endpackage

// File: rtl/mips_memsys_bootram.sv
// Boot RAM: one synchronous write port shared by loader and core, one asynchronous read port.
module bootram #(
  parameter int WIDTH   = 8,
  parameter int ADRBITS = 6
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADRBITS-1:0] wadr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [ADRBITS-1:0] radr_i,
  output logic [WIDTH-1:0]   rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADRBITS];

  // Contents are deliberately not reset so an image survives a system reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wadr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[radr_i];

endmodule

// File: rtl/mips_memsys.sv
// Memory subsystem for the mips core: loads a host image, then serves core reads/writes
// and one memory-mapped output register.
module mips_memsys
  import mips_memsys_pkg::*;
#(
  parameter int             WIDTH   = 8,
  parameter int             ADRBITS = 6,
  parameter int             LOADLEN = 64,
  parameter logic [WIDTH-1:0] IOADR = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic [7:0]       io_out,
  output logic             loaded
);

  localparam int LCNTW = ADRBITS + 1;

  memstate            state_q;
  logic [LCNTW-1:0]   lcnt_q;
  logic [7:0]         io_q;

  logic               ldFire;
  logic               loadEnd;
  logic               adrInRam;
  logic               adrIsIo;
  logic               ramWe;
  logic [ADRBITS-1:0] ramWadr;
  logic [WIDTH-1:0]   ramWdata;
  logic [WIDTH-1:0]   ramRdata;

  assign ld_ready  = (state_q == LOAD);
  assign cpu_reset = (state_q != RUN);
  assign loaded    = (state_q == RUN);
  assign io_out    = io_q;

  assign ldFire   = ld_ready & ld_valid;
  assign loadEnd  = ld_last | (lcnt_q == LCNTW'(LOADLEN - 1));
  assign adrInRam = (adr[WIDTH-1:ADRBITS] == '0);
  assign adrIsIo  = (adr == IOADR);

  // Sequencer: one idle cycle, stream the image, one START cycle so the core sees reset, then run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE:  state_q <= LOAD;
        LOAD: begin
          if (ldFire) begin
            lcnt_q <= lcnt_q + LCNTW'(1);
            if (loadEnd) state_q <= START;
          end
        end
        START: state_q <= RUN;
        RUN:   state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Loader and core share the single RAM write port; the state picks which one owns it.
  always_comb begin
    ramWe    = 1'b0;
    ramWadr  = lcnt_q[ADRBITS-1:0];
    ramWdata = WIDTH'(ld_data);
    if (state_q == LOAD) begin
      ramWe = ld_valid;
    end else if (state_q == RUN) begin
      ramWe    = memwrite & adrInRam;
      ramWadr  = adr[ADRBITS-1:0];
      ramWdata = writedata;
    end
  end

  // Output register is only writable by the core once it is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_q <= 8'h00;
    end else if ((state_q == RUN) && memwrite && adrIsIo) begin
      io_q <= writedata[7:0];
    end
  end

  // Zero-latency read decode: the core captures memdata on the same edge it asks.
  always_comb begin
    memdata = '0;
    if (memread) begin
      if (adrIsIo)       memdata = WIDTH'(io_q);
      else if (adrInRam) memdata = ramRdata;
    end
  end

  bootram #(
    .WIDTH   (WIDTH),
    .ADRBITS (ADRBITS)
  ) u_bootram (
    .clk     (clk),
    .we_i    (ramWe),
    .wadr_i  (ramWadr),
    .wdata_i (ramWdata),
    .radr_i  (adr[ADRBITS-1:0]),
    .rdata_o (ramRdata)
  );

endmodule

// File: tb/tb_mips_memsys.sv
// Randomized scoreboard bench for mips_memsys with a behavioural memory/loader model.
module tb_mips_memsys;

  localparam int         WIDTH   = 8;
  localparam int         ADRBITS = 6;
  localparam int         LOADLEN = 4;
  localparam int         RAMSIZE = 64;
  localparam logic [7:0] IOADR   = 8'hFF;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_START = 2;
  localparam int PH_RUN   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ldValid = 1'b0;
  logic [7:0] ldData = 8'h00;
  logic       ldLast = 1'b0;
  logic       ldReady;
  logic       cpuReset;
  logic       memRead = 1'b0;
  logic       memWrite = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] writeData = 8'h00;
  logic [7:0] memData;
  logic [7:0] ioOut;
  logic       loaded;

  int checks = 0;
  int failures = 0;

  logic [7:0] refRam [RAMSIZE];
  bit         known  [RAMSIZE];
  logic [7:0] refIo = 8'h00;
  int         refPhase = PH_IDLE;
  int         refCnt = 0;
  logic [7:0] expQ [$];

  mips_memsys #(
    .WIDTH   (WIDTH),
    .ADRBITS (ADRBITS),
    .LOADLEN (LOADLEN),
    .IOADR   (IOADR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ldValid),
    .ld_data   (ldData),
    .ld_last   (ldLast),
    .ld_ready  (ldReady),
    .cpu_reset (cpuReset),
    .memread   (memRead),
    .memwrite  (memWrite),
    .adr       (adr),
    .writedata (writeData),
    .memdata   (memData),
    .io_out    (ioOut),
    .loaded    (loaded)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Compare one observed value against the model and tally the result.
  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // What the core should read at an address, from the memory map rules.
  function automatic logic [7:0] refRead(input logic [7:0] a);
    if (a == IOADR) return refIo;
    if (a < 8'(RAMSIZE)) return refRam[a[5:0]];
    return 8'h00;
  endfunction

  // One clock cycle of stimulus; pushes expected read data and advances the model at the edge.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l,
                               input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    #1;
    ldValid = v; ldData = d; ldLast = l;
    memRead = rd; memWrite = wr; adr = a; writeData = wd;
    if (rd) expQ.push_back(refRead(a));
    @(negedge clk);
    checkOutput("ld_ready",  8'(ldReady),  8'(refPhase == PH_LOAD));
    checkOutput("cpu_reset", 8'(cpuReset), 8'(refPhase != PH_RUN));
    checkOutput("loaded",    8'(loaded),   8'(refPhase == PH_RUN));
    checkOutput("io_out",    ioOut,        refIo);
    if (!rd) checkOutput("memdata_gated", memData, 8'h00);
    @(posedge clk);
    case (refPhase)
      PH_IDLE:  refPhase = PH_LOAD;
      PH_LOAD: begin
        if (v) begin
          refRam[refCnt] = d;
          known[refCnt]  = 1'b1;
          refCnt++;
          if (l || refCnt == LOADLEN) refPhase = PH_START;
        end
      end
      PH_START: refPhase = PH_RUN;
      default: begin
        if (wr) begin
          if (a == IOADR) refIo = wd;
          else if (a < 8'(RAMSIZE)) begin
            refRam[a[5:0]] = wd;
            known[a[5:0]]  = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic readAt(input logic [7:0] a);
    applyStimulus(0, 8'h00, 0, 1, 0, a, 8'h00);
  endtask

  task automatic writeAt(input logic [7:0] a, input logic [7:0] wd);
    applyStimulus(0, 8'h00, 0, 0, 1, a, wd);
  endtask

  // Asynchronous reset pulse, checks its immediate effect, then the single IDLE cycle.
  task automatic doReset();
    #1;
    ldValid = 0; ldLast = 0; memRead = 0; memWrite = 0;
    reset = 1'b1;
    refIo = 8'h00; refCnt = 0; refPhase = PH_IDLE;
    #1;
    checkOutput("rst_cpu_reset", 8'(cpuReset), 8'h01);
    checkOutput("rst_io_out",    ioOut,        8'h00);
    checkOutput("rst_ld_ready",  8'(ldReady),  8'h00);
    checkOutput("rst_loaded",    8'(loaded),   8'h00);
    checkOutput("rst_memdata",   memData,      8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_ld_ready",  8'(ldReady),  8'h00);
    checkOutput("idle_cpu_reset", 8'(cpuReset), 8'h01);
    @(posedge clk);
    refPhase = PH_LOAD;
  endtask

  // Scoreboard monitor: every cycle the core reads, pop the expected byte and compare.
  always @(negedge clk) begin
    if (memRead === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL memdata_unexpected: got %h expected none", memData);
      end else begin
        checkOutput("memdata", memData, expQ.pop_front());
      end
    end
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] img [4];
    logic [7:0] a;
    int         guard;
    bit         rd;
    bit         wr;
    img[0] = 8'h80; img[1] = 8'h01; img[2] = 8'h02; img[3] = 8'h03;

    // Basic load with ld_last on the 4th byte, then START and RUN.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, img[i], (i == 3), 0, 0, 8'h00, 8'h00);
    idleCycles(2);
    for (int i = 0; i < 4; i++) readAt(8'(i));

    // RUN-phase accesses: RAM, output register, unmapped, no same-cycle forwarding.
    writeAt(8'h10, 8'h5A);
    readAt(8'h10);
    writeAt(8'hFF, 8'hC3);
    readAt(8'hFF);
    writeAt(8'h40, 8'h99);
    readAt(8'h40);
    applyStimulus(0, 8'h00, 0, 1, 1, 8'h10, 8'h66);
    readAt(8'h10);
    applyStimulus(1, 8'hEE, 1, 0, 0, 8'h00, 8'h00);
    writeAt(8'h04, 8'h77);

    // Randomized RUN traffic.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = IOADR;
        1:       a = 8'($urandom_range(64, 254));
        default: a = 8'($urandom_range(0, RAMSIZE - 1));
      endcase
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1)) && (a >= 8'(RAMSIZE) || known[a[5:0]]);
      applyStimulus(0, 8'h00, 0, rd, wr, a, 8'($urandom));
    end
    writeAt(8'hFF, 8'hC3);
    writeAt(8'h04, 8'h77);

    // Reset mid-run, then a length-capped load of 6 bytes with no ld_last.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'($urandom), 0, 0, 0, 8'h00, 8'h00);
    idleCycles(1);
    for (int i = 0; i < 5; i++) readAt(8'(i));

    // Handshake gaps: valid 1,0,0,1 around two bytes.
    doReset();
    applyStimulus(1, 8'hA1, 0, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 8'hA1, 0, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 8'hB2, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus(1, 8'hB2, 1, 0, 0, 8'h00, 8'h00);
    idleCycles(2);
    for (int i = 0; i < 3; i++) readAt(8'(i));

    // One-byte reload keeps earlier RAM contents.
    doReset();
    applyStimulus(1, 8'h3C, 1, 0, 0, 8'h00, 8'h00);
    idleCycles(2);
    for (int i = 0; i < 5; i++) readAt(8'(i));
    readAt(8'h10);

    // Random reloads with gaps, ignored core writes during load, then random accesses.
    for (int iter = 0; iter < 8; iter++) begin
      doReset();
      guard = 0;
      while (refPhase == PH_LOAD && guard < 30) begin
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
                      0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, RAMSIZE - 1)), 8'($urandom));
        guard++;
      end
      applyStimulus(0, 8'h00, 0, 0, 1, 8'h20, 8'hD7);
      idleCycles(1);
      for (int i = 0; i < 10; i++) begin
        a  = ($urandom_range(0, 4) == 0) ? IOADR : 8'($urandom_range(0, RAMSIZE - 1));
        wr = 1'($urandom_range(0, 1));
        rd = (a == IOADR) || known[a[5:0]];
        applyStimulus(0, 8'h00, 0, rd, wr, a, 8'($urandom));
      end
    end

    idleCycles(1);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
